change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: releases a soda, then pays out the change owed (0..4
// nickels, with larger values clamped to 4) as dimes first and then nickels.
// Each coin is paid over a 4-phase request/acknowledge handshake with the coin
// mechanism. Every handshake edge is guarded by a timeout. A timeout parks the
// machine in FAULT until reset.
module change_dispenser #(
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_soda,
  input  logic [2:0] i_change,
  input  logic       i_ack,
  output logic       o_soda_rel,
  output logic       o_dime,
  output logic       o_nickel,
  output logic       o_busy,
  output logic       o_drop,
  output logic       o_fault
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SODA,
    COIN_REQ,
    ACK_LOW,
    FAULT
  } state_t;

  state_t          state_q;
  logic [2:0]      remaining_q;
  logic [WW-1:0]   wait_q;
  logic            soda_rel_q;
  logic            dime_q;
  logic            nickel_q;
  logic            busy_q;
  logic            drop_q;
  logic            fault_q;

  logic [WW-1:0]   wait_d;
  logic            timeout_d;
  logic [2:0]      change_clamped_d;
  logic [2:0]      coin_value_d;

  // Helper terms used by the state machine: next wait count, timeout hit,
  // clamped change, and the value of the coin currently requested.
  always_comb begin
    wait_d           = wait_q + 1'b1;
    timeout_d        = (wait_d == WW'(TIMEOUT));
    change_clamped_d = (i_change > 3'd4) ? 3'd4 : i_change;
    coin_value_d     = dime_q ? 3'd2 : 3'd1;
  end

  // Main controller: state, change bookkeeping and every registered output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wait_q      <= '0;
      soda_rel_q  <= 1'b0;
      dime_q      <= 1'b0;
      nickel_q    <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      // Single-cycle pulses default low; a strobe outside IDLE is rejected.
      soda_rel_q <= 1'b0;
      drop_q     <= i_soda && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (i_soda) begin
            remaining_q <= change_clamped_d;
            soda_rel_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SODA;
          end
        end
        SODA: begin
          if (remaining_q != 3'd0) begin
            // Greedy coin choice: a dime whenever at least two nickels remain.
            dime_q   <= (remaining_q >= 3'd2);
            nickel_q <= (remaining_q == 3'd1);
            wait_q   <= '0;
            state_q  <= COIN_REQ;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        COIN_REQ: begin
          if (i_ack) begin
            dime_q      <= 1'b0;
            nickel_q    <= 1'b0;
            remaining_q <= remaining_q - coin_value_d;
            wait_q      <= '0;
            state_q     <= ACK_LOW;
          end else if (timeout_d) begin
            dime_q   <= 1'b0;
            nickel_q <= 1'b0;
            fault_q  <= 1'b1;
            state_q  <= FAULT;
          end else begin
            wait_q <= wait_d;
          end
        end
        ACK_LOW: begin
          if (!i_ack) begin
            if (remaining_q != 3'd0) begin
              dime_q   <= (remaining_q >= 3'd2);
              nickel_q <= (remaining_q == 3'd1);
              wait_q   <= '0;
              state_q  <= COIN_REQ;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (timeout_d) begin
            fault_q <= 1'b1;
            state_q <= FAULT;
          end else begin
            wait_q <= wait_d;
          end
        end
        FAULT: begin
          // Sticky: only reset leaves this state.
          fault_q  <= 1'b1;
          dime_q   <= 1'b0;
          nickel_q <= 1'b0;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_soda_rel = soda_rel_q;
  assign o_dime     = dime_q;
  assign o_nickel   = nickel_q;
  assign o_busy     = busy_q;
  assign o_drop     = drop_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: randomized vends against a transaction-level
// model (greedy coin list from the clamped change), with the bench acting as
// the coin mechanism. It also covers the timeout fault and the asynchronous
// reset cases.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       soda;
  logic [2:0] change;
  logic       ack;
  logic       o_soda_rel, o_dime, o_nickel, o_busy, o_drop, o_fault;

  int  total = 0;
  int  bad   = 0;
  bit  drop_exp = 1'b0;

  always #5 clk = ~clk;

  change_dispenser #(.TIMEOUT(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_soda     (soda),
    .i_change   (change),
    .i_ack      (ack),
    .o_soda_rel (o_soda_rel),
    .o_dime     (o_dime),
    .o_nickel   (o_nickel),
    .o_busy     (o_busy),
    .o_drop     (o_drop),
    .o_fault    (o_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // coin: 0 = no request, 1 = nickel, 2 = dime
  task automatic chk_req(input string tag, input int coin);
    chk({tag, "_dime"},   o_dime,   32'(coin == 2));
    chk({tag, "_nickel"}, o_nickel, 32'(coin == 1));
  endtask

  // Advance to the next sampling point and check the rejected-strobe pulse.
  task automatic cyc();
    @(negedge clk);
    chk("drop", o_drop, 32'(drop_exp));
    drop_exp = 1'b0;
    soda     = 1'b0;
  endtask

  // One vend. intr: 0 none, 1 extra strobe during SODA, 2 during first request.
  task automatic run_txn(input int ch, input int intr, input bit early_ack);
    int n;
    int coins[$];
    int r;
    int h;
    n = (ch > 4) ? 4 : ch;
    for (int k = 0; k < n / 2; k++) coins.push_back(2);
    if ((n % 2) == 1) coins.push_back(1);
    $display("txn change=%0d coins=%0d intr=%0d early_ack=%0d", ch, coins.size(), intr, early_ack);
    chk("pre_busy", o_busy, 0);
    soda   = 1'b1;
    change = 3'(ch);
    ack    = early_ack;
    cyc();
    chk("soda_rel", o_soda_rel, 1);
    chk("soda_busy", o_busy, 1);
    chk_req("soda_req", 0);
    ack = early_ack;
    if (intr == 1) begin
      soda = 1'b1; change = 3'($urandom_range(0, 7)); drop_exp = 1'b1;
    end
    cyc();
    chk("soda_rel_once", o_soda_rel, 0);
    ack = 1'b0;
    if (coins.size() == 0) begin
      chk("nochange_busy", o_busy, 0);
      chk_req("nochange_req", 0);
      return;
    end
    chk("first_busy", o_busy, 1);
    chk_req("first_req", coins[0]);
    if (intr == 2) begin
      soda = 1'b1; change = 3'($urandom_range(0, 7)); drop_exp = 1'b1;
    end
    for (int i = 0; i < coins.size(); i++) begin
      r = $urandom_range(0, 3);
      for (int j = 0; j < r; j++) begin
        cyc();
        chk_req("hold_req", coins[i]);
      end
      ack = 1'b1;
      cyc();
      chk_req("req_drop", 0);
      chk("acklow_busy", o_busy, 1);
      h = $urandom_range(0, 3);
      for (int j = 0; j < h; j++) begin
        cyc();
        chk_req("acklow_req", 0);
      end
      ack = 1'b0;
      cyc();
      chk("coin_soda_rel", o_soda_rel, 0);
      chk("coin_fault", o_fault, 0);
      if (i == coins.size() - 1) begin
        chk("end_busy", o_busy, 0);
        chk_req("end_req", 0);
      end else begin
        chk("next_busy", o_busy, 1);
        chk_req("next_req", coins[i + 1]);
      end
    end
  endtask

  // Idle cycles with random ack noise, which must have no effect.
  task automatic idle_gap(input int g);
    for (int i = 0; i < g; i++) begin
      ack = 1'($urandom_range(0, 1));
      cyc();
      chk("idle_busy", o_busy, 0);
      chk_req("idle_req", 0);
      chk("idle_soda_rel", o_soda_rel, 0);
    end
    ack = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; soda = 1'b0; change = 3'd0; ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_soda_rel", o_soda_rel, 0);
    chk_req("rst_req", 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_fault", o_fault, 0);
    rst = 1'b0;

    // Directed vends first, then randomized ones.
    run_txn(3, 0, 1'b0);
    run_txn(0, 0, 1'b0);
    run_txn(7, 2, 1'b0);
    run_txn(1, 1, 1'b1);
    for (int t = 0; t < 40; t++) begin
      idle_gap($urandom_range(0, 2));
      run_txn($urandom_range(0, 7), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Timeout: the request is never acknowledged.
    $display("txn timeout");
    soda = 1'b1; change = 3'd3;
    cyc();
    cyc();
    chk_req("to_req", 2);
    cnt = 0;
    while (o_fault !== 1'b1 && cnt < 20) begin
      cyc();
      cnt++;
    end
    chk("fault_latency", cnt, 8);
    chk("fault_flag", o_fault, 1);
    chk_req("fault_req", 0);
    chk("fault_busy", o_busy, 1);
    soda = 1'b1; change = 3'd2; drop_exp = 1'b1;
    cyc();
    chk("fault_sticky", o_fault, 1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    cyc();
    chk_req("fault_ack_req", 0);
    chk("fault_sticky2", o_fault, 1);
    #2 rst = 1'b1;
    #1;
    chk("frst_fault", o_fault, 0);
    chk("frst_busy", o_busy, 0);
    chk_req("frst_req", 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(4, 0, 1'b0);

    // Reset in the middle of a dime handshake with ack high.
    $display("txn reset_mid_handshake");
    soda = 1'b1; change = 3'd2;
    cyc();
    cyc();
    chk_req("mid_req", 2);
    ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_req("arst_req", 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_fault", o_fault, 0);
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    run_txn(2, 0, 1'b0);
    run_txn(5, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
